// File: rtl/rroce_pkg.sv
// Shared types and constants for the RoCE send scheduler.
// State encoding, counter and QP widths, plus basic RoCEv2 constants.
package rroce_pkg;

   localparam int QP_W  = 24;
   localparam int CNT_W = 16;
   localparam int GID_W = 3;

   localparam logic [15:0] ROCE_UDP_PORT    = 16'd4791;
   localparam logic [7:0]  BTH_OP_SEND_ONLY = 8'h04;
   localparam logic [15:0] ROCE_PKEY_DEF    = 16'hFFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_GAP
   } state_e;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [QP_W-1:0]  qp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts one past last_grant; grant is one-hot or zero.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   last_grant,
   output logic [N-1:0] grant,
   output logic         valid
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   int            sum;
   logic [IW-1:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      sum   = 0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         sum = int'(last_grant) + k;
         if (sum >= N) sum = sum - N;
         idx = IW'(sum);
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rroce_send_sched.sv
// Round-robin send scheduler feeding one RoCE packet generator.
// Grants a requester, starts a send, waits for done or timeout, then idles.
module rroce_send_sched
   import rroce_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int PAYLOAD_LEN = 56,
   parameter int TIMEOUT_CYC = 1024,
   parameter int GAP_CYC     = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*QP_W-1:0]       req_qp,
   input  logic [NUM_REQ*PAYLOAD_LEN*8-1:0] req_payload,
   output logic [QP_W-1:0]               dest_qp,
   output logic [PAYLOAD_LEN*8-1:0]      payload_data,
   output logic                          send_start,
   input  logic                          send_done,
   output logic [GID_W-1:0]              grant_id,
   output logic                          busy,
   output logic                          timeout_err,
   output logic [NUM_REQ*CNT_W-1:0]      sent_cnt
);

   localparam int   PLW      = PAYLOAD_LEN * 8;
   localparam cnt_t TMO_LAST = cnt_t'(TIMEOUT_CYC - 1);
   localparam cnt_t GAP_LAST = cnt_t'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

   state_e                       state_q, state_d;
   cnt_t                         cnt_q, cnt_d;
   logic [GID_W-1:0]             last_q, last_d;
   logic [GID_W-1:0]             gid_q, gid_d;
   qp_t                          qp_q, qp_d;
   logic [PLW-1:0]               pl_q, pl_d;
   logic [NUM_REQ-1:0][CNT_W-1:0] sent_q, sent_d;

   logic [NUM_REQ-1:0] gnt;
   logic               gnt_vld;
   logic [GID_W-1:0]   gidx;
   qp_t                qp_sel;
   logic [PLW-1:0]     pl_sel;

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_arb (
      .req       (req_valid),
      .last_grant(last_q),
      .grant     (gnt),
      .valid     (gnt_vld)
   );

   always_comb begin
      gidx   = '0;
      qp_sel = '0;
      pl_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            gidx   = GID_W'(i);
            qp_sel = req_qp[i*QP_W +: QP_W];
            pl_sel = req_payload[i*PLW +: PLW];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      gid_d       = gid_q;
      qp_d        = qp_q;
      pl_d        = pl_q;
      sent_d      = sent_q;
      req_ready   = '0;
      send_start  = 1'b0;
      timeout_err = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               req_ready = gnt & req_valid;
               gid_d     = gidx;
               last_d    = gidx;
               qp_d      = qp_sel;
               pl_d      = pl_sel;
               state_d   = S_START;
            end
         end
         S_START: begin
            send_start = 1'b1;
            cnt_d      = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            // done wins over a timeout landing on the same cycle
            if (send_done) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (gid_q == GID_W'(i)) sent_d[i] = sent_q[i] + 16'd1;
               end
               cnt_d   = '0;
               state_d = S_GAP;
            end else if (cnt_q == TMO_LAST) begin
               timeout_err = 1'b1;
               cnt_d       = '0;
               state_d     = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q >= GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         last_q  <= GID_W'(NUM_REQ - 1);
         gid_q   <= '0;
         qp_q    <= '0;
         pl_q    <= '0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         qp_q    <= qp_d;
         pl_q    <= pl_d;
         sent_q  <= sent_d;
      end
   end

   assign dest_qp      = qp_q;
   assign payload_data = pl_q;
   assign grant_id     = gid_q;
   assign busy         = (state_q != S_IDLE);
   assign sent_cnt     = sent_q;

endmodule

// File: tb/tb_rroce_send_sched.sv
// Scoreboard bench for rroce_send_sched.
// Expected grants are queued at stimulus and popped on send_start.
module tb_rroce_send_sched;
   import rroce_pkg::*;

   localparam int NR  = 4;
   localparam int PL  = 56;
   localparam int TMO = 16;
   localparam int GAP = 4;
   localparam int PW  = PL * 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR*24-1:0]  req_qp = '0;
   logic [NR*PW-1:0]  req_payload = '0;
   logic [23:0]       dest_qp;
   logic [PW-1:0]     payload_data;
   logic              send_start;
   logic              send_done;
   logic [2:0]        grant_id;
   logic              busy;
   logic              timeout_err;
   logic [NR*16-1:0]  sent_cnt;

   rroce_send_sched #(
      .NUM_REQ    (NR),
      .PAYLOAD_LEN(PL),
      .TIMEOUT_CYC(TMO),
      .GAP_CYC    (GAP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_qp      (req_qp),
      .req_payload (req_payload),
      .dest_qp     (dest_qp),
      .payload_data(payload_data),
      .send_start  (send_start),
      .send_done   (send_done),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err),
      .sent_cnt    (sent_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]    g;
      logic [23:0]   qp;
      logic [PW-1:0] pl;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;
   int starts = 0;
   int start_cyc = 0;
   int gap_last = 0;
   int tmo_n = 0;
   int tmo_cyc = 0;
   int busy_n = 0;
   int done_dly = -1;
   int dcnt = 0;
   logic done_pulse = 1'b0;
   logic stray = 1'b0;

   assign send_done = done_pulse | stray;

   task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] pay(int i);
      logic [31:0] w;
      w = 32'h5A3C0000 + 32'(i) * 32'h1111;
      return {14{w}};
   endfunction

   always @(posedge clk) cyc_n++;

   always @(negedge clk) begin
      #1;
      if (timeout_err) begin
         tmo_n++;
         tmo_cyc = cyc_n;
      end
      if (busy) busy_n++;
      if (send_start) begin
         gap_last  = cyc_n - start_cyc;
         start_cyc = cyc_n;
         starts++;
         if (exp_q.size() == 0) begin
            chk("start_unexp", 1, 0);
         end else begin
            e_mon = exp_q.pop_front();
            chk("gid", grant_id, e_mon.g);
            chk("qp", dest_qp, e_mon.qp);
            chk("pay", payload_data, e_mon.pl);
         end
      end
   end

   always @(negedge clk) begin
      done_pulse = 1'b0;
      if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) done_pulse = 1'b1;
      end
      if (send_start && done_dly > 0) dcnt = done_dly;
   end

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push(int id, logic [23:0] qp);
      exp_t e;
      e.g  = 3'(id);
      e.qp = qp;
      e.pl = pay(id);
      req_qp[id*24 +: 24] = qp;
      exp_q.push_back(e);
   endtask

   task automatic send_one(int id, logic [23:0] qp, int dly, output int g_cyc);
      push(id, qp);
      done_dly = dly;
      req_valid[id] = 1'b1;
      g_cyc = -1;
      for (int k = 0; k < 200 && g_cyc < 0; k++) begin
         #1;
         if (req_ready[id]) g_cyc = cyc_n;
         @(negedge clk);
      end
      if (g_cyc < 0) chk("grant_to", 0, 1);
      else chk("rdy_1cyc", req_ready, 0);
      req_valid[id] = 1'b0;
      #2;
   endtask

   task automatic wait_idle(output int icyc);
      icyc = -1;
      for (int k = 0; k < 400; k++) begin
         if (!busy && exp_q.size() == 0) begin
            icyc = cyc_n;
            break;
         end
         @(negedge clk);
      end
      if (icyc < 0) chk("idle_to", 0, 1);
      #2;
   endtask

   task automatic run_multi(logic [NR-1:0] v, int n, int dly);
      int base;
      int ok;
      int ic;
      base = starts;
      ok = 0;
      done_dly = dly;
      req_valid = v;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         #2;
         if (starts - base >= n) begin
            ok = 1;
            break;
         end
      end
      req_valid = '0;
      if (ok == 0) chk("multi_to", 0, 1);
      wait_idle(ic);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int g;
      int ic;
      int tb0;
      int bb;

      for (int i = 0; i < NR; i++) req_payload[i*PW +: PW] = pay(i);

      do_reset();
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_start", send_start, 0);
      chk("rst_tmo", timeout_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_qp", dest_qp, 0);
      chk("rst_pay", payload_data, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_cnt", sent_cnt, 0);

      // single request on requester 1
      req_valid = 4'b0010;
      req_qp[24 +: 24] = 24'h000011;
      #1;
      chk("single_rdy", req_ready, 4'b0010);
      req_valid = '0;
      send_one(1, 24'h000011, 10, g);
      chk("lat", start_cyc - g, 1);
      wait_idle(ic);
      chk("busy_len", ic - start_cyc, 10 + GAP + 1);
      chk("single_cnt", sent_cnt[16 +: 16], 1);

      // back-to-back spacing with immediate completion
      push(2, 24'h000202);
      push(3, 24'h000303);
      run_multi(4'b1100, 2, 1);
      chk("spacing", gap_last, 3 + GAP);

      // fairness
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NR; i++) push(i, 24'h000100 + 24'(i));
      run_multi(4'b1111, 8, 5);
      for (int i = 0; i < NR; i++) chk("fair_cnt", sent_cnt[i*16 +: 16], 2);

      // timeout then next request served
      do_reset();
      tb0 = tmo_n;
      send_one(0, 24'h000020, -1, g);
      wait_idle(ic);
      chk("tmo_n", tmo_n - tb0, 1);
      chk("tmo_dt", tmo_cyc - start_cyc, TMO);
      chk("tmo_cnt", sent_cnt[0 +: 16], 0);
      send_one(1, 24'h000021, 5, g);
      wait_idle(ic);
      chk("post_tmo_cnt", sent_cnt[16 +: 16], 1);
      chk("post_tmo_n", tmo_n - tb0, 1);

      // done on final timeout cycle
      do_reset();
      tb0 = tmo_n;
      send_one(3, 24'h000033, TMO, g);
      wait_idle(ic);
      chk("sim_tmo_n", tmo_n - tb0, 0);
      chk("sim_cnt", sent_cnt[48 +: 16], 1);

      // reset in the middle of WAIT
      do_reset();
      send_one(0, 24'h000044, 5, g);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_start", send_start, 0);
      chk("mid_ready", req_ready, 0);
      chk("mid_qp", dest_qp, 0);
      chk("mid_gid", grant_id, 0);
      chk("mid_pay", payload_data, 0);
      @(negedge clk);
      rst = 1'b0;
      bb  = busy_n;
      tb0 = tmo_n;
      repeat (12) @(negedge clk);
      #2;
      chk("mid_nobusy", busy_n - bb, 0);
      chk("mid_cnt", sent_cnt, 0);
      chk("mid_tmo", tmo_n - tb0, 0);

      // counter wrap and stray done in IDLE
      do_reset();
      force dut.sent_q[2] = 16'hFFFF;
      @(negedge clk);
      release dut.sent_q[2];
      #2;
      chk("wrap_pre", sent_cnt[32 +: 16], 16'hFFFF);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      @(negedge clk);
      #2;
      chk("stray_cnt", sent_cnt, {16'h0, 16'hFFFF, 16'h0, 16'h0});
      chk("stray_busy", busy, 0);
      send_one(2, 24'h000022, 3, g);
      wait_idle(ic);
      chk("wrap_cnt", sent_cnt[32 +: 16], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
